// File: rtl/approx_mul_error_monitor_if.sv
// rtl/approx_mul_error_monitor_if.sv - sample handshake bundle between the stimulus source and the error monitor
//
// Signals:
//   in_valid  source -> monitor  sample valid
//   in_ready  monitor -> source  sample accepted when in_valid & in_ready
//   in_a      source -> monitor  operand A, also fed to the approximate multiplier
//   in_b      source -> monitor  operand B, also fed to the approximate multiplier
//   approx_p  source -> monitor  approximate product for in_a/in_b, same cycle
interface approx_mul_error_monitor_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [2*WIDTH-1:0]   approx_p;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output approx_p,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  approx_p,
    output in_ready
  );
endinterface

// File: rtl/approx_mul_error_monitor.sv
// rtl/approx_mul_error_monitor.sv - batch error-distance characterisation of an approximate multiplier
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      single-cycle request to begin a batch (honoured in IDLE/DONE only)
//   smp        sample handshake (slave side): in_valid/in_ready/in_a/in_b/approx_p
//   busy       batch in progress (RUN or DRAIN)
//   done       one-cycle pulse, results final
//   err_count  samples with nonzero error distance
//   sum_ed     sum of error distance over the batch
//   mean_ed    sum_ed >> BATCH_LOG2, truncated
//   max_ed     largest error distance seen
//   max_a      operand A of the first sample reaching max_ed
//   max_b      operand B of the first sample reaching max_ed
module approx_mul_error_monitor #(
  parameter int WIDTH      = 8,
  parameter int BATCH_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  approx_mul_error_monitor_if.slave     smp,
  output logic                          busy,
  output logic                          done,
  output logic [BATCH_LOG2:0]           err_count,
  output logic [2*WIDTH+BATCH_LOG2-1:0] sum_ed,
  output logic [2*WIDTH-1:0]            mean_ed,
  output logic [2*WIDTH-1:0]            max_ed,
  output logic [WIDTH-1:0]              max_a,
  output logic [WIDTH-1:0]              max_b
);

  localparam logic [BATCH_LOG2:0] NSAMP    = {1'b1, {BATCH_LOG2{1'b0}}};
  localparam logic [BATCH_LOG2:0] LAST_IDX = NSAMP - 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [BATCH_LOG2:0] accepted;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [2*WIDTH-1:0]   s1_p;

  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_a;
  logic [WIDTH-1:0]     s2_b;
  logic [2*WIDTH-1:0]   s2_ed;

  logic                 accept;
  logic                 start_ok;
  logic [2*WIDTH-1:0]   exact;
  logic [2*WIDTH-1:0]   ed;

  // in_ready comes only from registered state, so the source never sees a
  // combinational path from its own in_valid.
  assign smp.in_ready = (state == RUN) && (accepted < NSAMP);
  assign accept       = smp.in_valid && smp.in_ready;
  assign start_ok     = start && ((state == IDLE) || (state == DONE));
  assign busy         = (state == RUN) || (state == DRAIN);
  assign mean_ed      = sum_ed[2*WIDTH+BATCH_LOG2-1:BATCH_LOG2];

  assign exact = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
  assign ed    = (exact >= s1_p) ? (exact - s1_p) : (s1_p - exact);

  // S1 captures the accepted sample, S2 holds its error distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_ed    <= '0;
    end else if (start_ok) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= smp.in_a;
        s1_b <= smp.in_b;
        s1_p <= smp.approx_p;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a  <= s1_a;
        s2_b  <= s1_b;
        s2_ed <= ed;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      accepted  <= '0;
      done      <= 1'b0;
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
      max_a     <= '0;
      max_b     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            accepted  <= '0;
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            max_a     <= '0;
            max_b     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            accepted <= accepted + 1'b1;
            if (accepted == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          // No accepts happen here, so once S1 is empty the sample in S2
          // is the last one of the batch.
          if (s2_valid && !s1_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (s2_valid && ((state == RUN) || (state == DRAIN))) begin
        sum_ed    <= sum_ed + {{BATCH_LOG2{1'b0}}, s2_ed};
        err_count <= err_count + {{BATCH_LOG2{1'b0}}, (s2_ed != '0)};
        // Strict compare: on a tie the earlier sample's operands are kept.
        if (s2_ed > max_ed) begin
          max_ed <= s2_ed;
          max_a  <= s2_a;
          max_b  <= s2_b;
        end
      end
    end
  end

endmodule
